// File: rtl/mips_defs.sv
// Shared MIPS encodings and the control-transfer classifier used by the fetch unit.
package mips_defs;

  localparam logic [5:0]  OP_SPECIAL   = 6'b000000;
  localparam logic [5:0]  OP_REGIMM    = 6'b000001;
  localparam logic [5:0]  OP_J         = 6'b000010;
  localparam logic [5:0]  OP_JAL       = 6'b000011;
  localparam logic [5:0]  OP_BEQ       = 6'b000100;
  localparam logic [5:0]  OP_BNE       = 6'b000101;
  localparam logic [5:0]  FN_JR        = 6'b001000;
  localparam logic [5:0]  FN_JALR      = 6'b001001;
  localparam logic [4:0]  RT_BLTZ      = 5'b00000;
  localparam logic [4:0]  RT_BGEZ      = 5'b00001;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [2:0] {
    XF_NONE,
    XF_BEQ,
    XF_BNE,
    XF_BGEZ,
    XF_BLTZ,
    XF_JUMP,
    XF_JREG
  } xfer_e;

  function automatic xfer_e decode_xfer(input logic [31:0] instr);
    xfer_e kind;
    kind = XF_NONE;
    case (instr[31:26])
      OP_BEQ:       kind = XF_BEQ;
      OP_BNE:       kind = XF_BNE;
      OP_REGIMM: begin
        if (instr[20:16] == RT_BGEZ)      kind = XF_BGEZ;
        else if (instr[20:16] == RT_BLTZ) kind = XF_BLTZ;
      end
      OP_J, OP_JAL: kind = XF_JUMP;
      OP_SPECIAL: begin
        if (instr[5:0] == FN_JR || instr[5:0] == FN_JALR) kind = XF_JREG;
      end
      default:      kind = XF_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Decodes the instruction in ID, resolves whether it transfers control and
// picks the next fetch address.
module npc_calc
  import mips_defs::*;
(
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc4,
  input  logic [31:0] pc_if,
  input  logic        cmp_equal,
  input  logic        cmp_bgez,
  input  logic [31:0] rs_data,
  input  logic        redirect,
  output logic        take,
  output logic [31:0] npc
);

  xfer_e       kind;
  logic [31:0] br_off;
  logic [31:0] target;

  assign kind   = decode_xfer(id_instr);
  assign br_off = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};

  always_comb begin
    take   = 1'b0;
    target = id_pc4 + br_off;
    case (kind)
      XF_BEQ:  take = cmp_equal;
      XF_BNE:  take = !cmp_equal;
      XF_BGEZ: take = cmp_bgez;
      XF_BLTZ: take = !cmp_bgez;
      XF_JUMP: begin
        take   = 1'b1;
        target = {id_pc4[31:28], id_instr[25:0], 2'b00};
      end
      XF_JREG: begin
        take   = 1'b1;
        target = rs_data;
      end
      default: take = 1'b0;
    endcase
  end

  // Caller qualifies take with valid/stall before it steers the PC.
  assign npc = redirect ? target : pc_if + 32'd4;

endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage and IF/ID register: PC, fetched-instruction latch, redirect and
// a saturating count of taken control transfers.
module fetch_pc_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] instr_if,
  input  logic        cmp_equal,
  input  logic        cmp_bgez,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_if,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        redirect,
  output logic [31:0] taken_count
);

  logic        take;
  logic [31:0] npc;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_if + 32'd4;
  // Operands are not final during a stall, so the branch waits and re-resolves.
  assign redirect = id_valid & !stall & take;

  npc_calc u_npc_calc (
    .id_instr  (id_instr),
    .id_pc4    (id_pc4),
    .pc_if     (pc_if),
    .cmp_equal (cmp_equal),
    .cmp_bgez  (cmp_bgez),
    .rs_data   (rs_data),
    .redirect  (redirect),
    .take      (take),
    .npc       (npc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_if       <= RESET_PC;
      id_instr    <= NOP;
      id_pc4      <= 32'd0;
      id_valid    <= 1'b0;
      taken_count <= 32'd0;
    end else if (!stall) begin
      pc_if <= npc;
      if (!DELAY_SLOT && redirect) begin
        id_instr <= NOP;
        id_pc4   <= 32'd0;
        id_valid <= 1'b0;
      end else begin
        id_instr <= instr_if;
        id_pc4   <= pc_plus4;
        id_valid <= 1'b1;
      end
      if (redirect && taken_count != 32'hFFFF_FFFF) begin
        taken_count <= taken_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a delay-slot and a squashing instance share one
// stimulus stream and are checked against an abstract per-cycle model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n, stall, cmp_equal, cmp_bgez;
  logic [31:0] instr_if, rs_data;

  logic [31:0] pc_a, id_instr_a, id_pc4_a, cnt_a;
  logic        id_valid_a, redirect_a;
  logic [31:0] pc_b, id_instr_b, id_pc4_b, cnt_b;
  logic        id_valid_b, redirect_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
  } mstate_t;

  mstate_t m1, m0;
  logic    rd_a, rd_b, xrd_a, xrd_b;

  localparam logic [31:0] ADDI = 32'h2000_0000;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .instr_if(instr_if),
    .cmp_equal(cmp_equal), .cmp_bgez(cmp_bgez), .rs_data(rs_data),
    .pc_if(pc_a), .id_instr(id_instr_a), .id_pc4(id_pc4_a),
    .id_valid(id_valid_a), .redirect(redirect_a), .taken_count(cnt_a)
  );

  fetch_pc_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .instr_if(instr_if),
    .cmp_equal(cmp_equal), .cmp_bgez(cmp_bgez), .rs_data(rs_data),
    .pc_if(pc_b), .id_instr(id_instr_b), .id_pc4(id_pc4_b),
    .id_valid(id_valid_b), .redirect(redirect_b), .taken_count(cnt_b)
  );

  // ---------------- reference model ----------------
  function automatic logic m_take(input logic [31:0] ins, input logic eq, input logic ge);
    case (ins[31:26])
      6'd4:       return eq;
      6'd5:       return !eq;
      6'd1: begin
        if (ins[20:16] == 5'd1) return ge;
        if (ins[20:16] == 5'd0) return !ge;
        return 1'b0;
      end
      6'd2, 6'd3: return 1'b1;
      6'd0:       return (ins[5:0] == 6'h08) || (ins[5:0] == 6'h09);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input mstate_t s);
    int off;
    off = int'($signed(s.instr[15:0]));
    case (s.instr[31:26])
      6'd1, 6'd4, 6'd5: return s.pc4 + unsigned'(off * 4);
      6'd2, 6'd3:       return (s.pc4 & 32'hF000_0000) | (32'(s.instr[25:0]) * 32'd4);
      default:          return rs_data;
    endcase
  endfunction

  function automatic logic m_redir(input mstate_t s);
    return s.valid && !stall && m_take(s.instr, cmp_equal, cmp_bgez);
  endfunction

  function automatic mstate_t m_next(input mstate_t s, input bit ds);
    mstate_t n;
    logic r;
    longint unsigned c;
    n = s;
    if (!reset_n) begin
      n = '0;
      n.pc = 32'h0000_3000;
      return n;
    end
    if (stall) return s;
    r = m_redir(s);
    n.pc = r ? m_target(s) : s.pc + 32'd4;
    if (r && !ds) begin
      n.instr = 32'd0; n.pc4 = 32'd0; n.valid = 1'b0;
    end else begin
      n.instr = instr_if; n.pc4 = s.pc + 32'd4; n.valid = 1'b1;
    end
    c = longint'(s.cnt) + (r ? 64'd1 : 64'd0);
    n.cnt = (c > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : c[31:0];
    return n;
  endfunction

  // One clock: drive at negedge, sample redirect 1 time unit later, advance
  // the models at posedge, return at the following negedge.
  task automatic step(input logic rn, input logic st, input logic [31:0] ins,
                      input logic eq, input logic ge, input logic [31:0] rs);
    reset_n = rn; stall = st; instr_if = ins;
    cmp_equal = eq; cmp_bgez = ge; rs_data = rs;
    #1;
    rd_a = redirect_a; rd_b = redirect_b;
    xrd_a = m_redir(m1); xrd_b = m_redir(m0);
    @(posedge clk);
    m1 = m_next(m1, 1'b1);
    m0 = m_next(m0, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0);
    n_cmp++; if (pc_a !== 32'h3000)   begin n_err++; $display("FAIL reset_pc: got %h expected %h", pc_a, 32'h3000); end
    n_cmp++; if (id_instr_a !== 32'd0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", id_instr_a); end
    n_cmp++; if (id_pc4_a !== 32'd0)   begin n_err++; $display("FAIL reset_pc4: got %h expected 0", id_pc4_a); end
    n_cmp++; if (id_valid_a !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b expected 0", id_valid_a); end
    n_cmp++; if (cnt_a !== 32'd0)      begin n_err++; $display("FAIL reset_count: got %h expected 0", cnt_a); end
    n_cmp++; if (rd_a !== 1'b0)        begin n_err++; $display("FAIL reset_redirect: got %b expected 0", rd_a); end
    n_cmp++; if (pc_b !== 32'h3000 || id_valid_b !== 1'b0) begin
      n_err++; $display("FAIL reset_ds0: got pc %h valid %b expected 3000 0", pc_b, id_valid_b);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0, ADDI + 32'(k), 1'b0, 1'b0, 32'd0);
      exp = 32'h3000 + 32'(4 * k);
      n_cmp++; if (pc_a !== exp || id_pc4_a !== exp || id_valid_a !== 1'b1 || id_instr_a !== ADDI + 32'(k)) begin
        n_err++;
        $display("FAIL seq_%0d: got pc %h pc4 %h valid %b instr %h expected %h %h 1 %h",
                 k, pc_a, id_pc4_a, id_valid_a, id_instr_a, exp, exp, ADDI + 32'(k));
      end
    end
  endtask

  task automatic test_beq();
    do_reset();
    step(1'b1, 1'b0, 32'h1000_0003, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, ADDI + 32'd1, 1'b1, 1'b0, 32'd0);
    n_cmp++; if (rd_a !== 1'b1) begin n_err++; $display("FAIL beq_redirect: got %b expected 1", rd_a); end
    n_cmp++; if (pc_a !== 32'h3010) begin n_err++; $display("FAIL beq_pc: got %h expected %h", pc_a, 32'h3010); end
    n_cmp++; if (id_instr_a !== ADDI + 32'd1 || id_pc4_a !== 32'h3008 || id_valid_a !== 1'b1) begin
      n_err++; $display("FAIL beq_delay_slot: got instr %h pc4 %h valid %b expected %h 3008 1",
                        id_instr_a, id_pc4_a, id_valid_a, ADDI + 32'd1);
    end
    n_cmp++; if (cnt_a !== 32'd1) begin n_err++; $display("FAIL beq_count: got %h expected 1", cnt_a); end
    n_cmp++; if (id_valid_b !== 1'b0 || id_instr_b !== 32'd0 || pc_b !== 32'h3010) begin
      n_err++; $display("FAIL beq_squash: got valid %b instr %h pc %h expected 0 0 3010", id_valid_b, id_instr_b, pc_b);
    end
    do_reset();
    step(1'b1, 1'b0, 32'h1000_0003, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, ADDI, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (rd_a !== 1'b0 || pc_a !== 32'h3008 || cnt_a !== 32'd0) begin
      n_err++; $display("FAIL beq_not_taken: got redirect %b pc %h count %h expected 0 3008 0", rd_a, pc_a, cnt_a);
    end
  endtask

  task automatic test_regimm();
    do_reset();
    step(1'b1, 1'b0, ADDI, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'h0401_FFFF, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, ADDI, 1'b0, 1'b1, 32'd0);
    n_cmp++; if (rd_a !== 1'b1 || pc_a !== 32'h3004) begin
      n_err++; $display("FAIL bgez_back: got redirect %b pc %h expected 1 3004", rd_a, pc_a);
    end
    do_reset();
    step(1'b1, 1'b0, ADDI, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'h0400_FFFF, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, ADDI, 1'b0, 1'b1, 32'd0);
    n_cmp++; if (rd_a !== 1'b0 || pc_a !== 32'h300C) begin
      n_err++; $display("FAIL bltz_not_taken: got redirect %b pc %h expected 0 300c", rd_a, pc_a);
    end
  endtask

  task automatic test_jump();
    do_reset();
    step(1'b1, 1'b0, 32'h0C00_0C10, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, ADDI, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (rd_a !== 1'b1 || pc_a !== 32'h3040) begin
      n_err++; $display("FAIL jal_target: got redirect %b pc %h expected 1 3040", rd_a, pc_a);
    end
    n_cmp++; if (id_valid_b !== 1'b0 || id_instr_b !== 32'd0) begin
      n_err++; $display("FAIL jal_squash: got valid %b instr %h expected 0 0", id_valid_b, id_instr_b);
    end
    step(1'b1, 1'b0, 32'h03E0_0008, 1'b0, 1'b0, 32'h0000_3100);
    step(1'b1, 1'b0, ADDI, 1'b0, 1'b0, 32'h0000_3100);
    n_cmp++; if (pc_a !== 32'h3100 || pc_b !== 32'h3100 || cnt_a !== 32'd2) begin
      n_err++; $display("FAIL jr_target: got pc %h / %h count %h expected 3100 3100 2", pc_a, pc_b, cnt_a);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b1, 1'b0, 32'h1000_0003, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, ADDI, 1'b1, 1'b0, 32'd0);
      n_cmp++; if (rd_a !== 1'b0 || pc_a !== 32'h3004 || id_instr_a !== 32'h1000_0003 || id_valid_a !== 1'b1) begin
        n_err++; $display("FAIL stall_hold_%0d: got redirect %b pc %h instr %h valid %b expected 0 3004 10000003 1",
                          k, rd_a, pc_a, id_instr_a, id_valid_a);
      end
    end
    step(1'b1, 1'b0, ADDI, 1'b1, 1'b0, 32'd0);
    n_cmp++; if (rd_a !== 1'b1 || pc_a !== 32'h3010) begin
      n_err++; $display("FAIL stall_release: got redirect %b pc %h expected 1 3010", rd_a, pc_a);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    force u_ds1.taken_count = 32'hFFFF_FFFE;
    force u_ds0.taken_count = 32'hFFFF_FFFE;
    #1;
    release u_ds1.taken_count;
    release u_ds0.taken_count;
    m1.cnt = 32'hFFFF_FFFE;
    m0.cnt = 32'hFFFF_FFFE;
    n_cmp++; if (cnt_a !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sat_preload: got %h expected fffffffe", cnt_a); end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 32'h0800_0C00, 1'b0, 1'b0, 32'd0);
      n_cmp++; if (cnt_a !== m1.cnt || cnt_b !== m0.cnt) begin
        n_err++; $display("FAIL sat_step_%0d: got %h / %h expected %h / %h", k, cnt_a, cnt_b, m1.cnt, m0.cnt);
      end
    end
    n_cmp++; if (cnt_a !== 32'hFFFF_FFFF || cnt_b !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL sat_final: got %h / %h expected ffffffff", cnt_a, cnt_b);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b0, 32'h1000_0003, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, ADDI, 1'b1, 1'b0, 32'd0);
    n_cmp++; if (pc_a !== 32'h3000 || id_valid_a !== 1'b0 || cnt_a !== 32'd0) begin
      n_err++; $display("FAIL reset_in_stall: got pc %h valid %b count %h expected 3000 0 0", pc_a, id_valid_a, cnt_a);
    end
    step(1'b1, 1'b0, 32'h1000_0003, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, ADDI, 1'b1, 1'b0, 32'd0);
    n_cmp++; if (pc_a !== 32'h3000 || id_valid_a !== 1'b0 || cnt_a !== 32'd0 || pc_b !== 32'h3000) begin
      n_err++; $display("FAIL reset_in_redirect: got pc %h valid %b count %h pc_ds0 %h expected 3000 0 0 3000",
                        pc_a, id_valid_a, cnt_a, pc_b);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       return {6'd4, r[25:0]};
      1:       return {6'd5, r[25:0]};
      2:       return {6'd1, r[25:21], 5'd1, r[15:0]};
      3:       return {6'd1, r[25:21], 5'd0, r[15:0]};
      4:       return {6'd2, r[25:0]};
      5:       return {6'd3, r[25:0]};
      6:       return {6'd0, r[25:6], 6'h08};
      7:       return {6'd0, r[25:6], 6'h09};
      8:       return {6'd8, r[25:0]};
      default: return r;
    endcase
  endfunction

  task automatic test_random();
    logic rn, st;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rn = ($urandom_range(0, 99) >= 2);
      st = ($urandom_range(0, 3) == 0);
      step(rn, st, rand_instr(), 1'($urandom), 1'($urandom), $urandom);
      n_cmp++; if (rd_a !== xrd_a || rd_b !== xrd_b) begin
        n_err++; $display("FAIL rand_redirect_%0d: got %b %b expected %b %b", k, rd_a, rd_b, xrd_a, xrd_b);
      end
      n_cmp++; if ({pc_a, id_instr_a, id_pc4_a, id_valid_a, cnt_a} !== m1) begin
        n_err++; $display("FAIL rand_state_ds1_%0d: got %h expected %h", k,
                          {pc_a, id_instr_a, id_pc4_a, id_valid_a, cnt_a}, m1);
      end
      n_cmp++; if ({pc_b, id_instr_b, id_pc4_b, id_valid_b, cnt_b} !== m0) begin
        n_err++; $display("FAIL rand_state_ds0_%0d: got %h expected %h", k,
                          {pc_b, id_instr_b, id_pc4_b, id_valid_b, cnt_b}, m0);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; instr_if = 32'd0;
    cmp_equal = 1'b0; cmp_bgez = 1'b0; rs_data = 32'd0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_beq();
    test_regimm();
    test_jump();
    test_stall();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Holds the PC and latches the fetched instruction and PC+4 into IF/ID.
- Decodes branch/jump instructions sitting in ID and consumes the ID-stage comparator flags (equal, greater-or-equal-zero).
- Selects the next PC and counts taken control transfers.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- DELAY_SLOT, 1, 1 = MIPS delay slot executes; 0 = squash IF/ID on redirect.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- stall  in  1  hazard-unit stall; freezes PC and IF/ID.
- instr_if  in  32  instruction memory read data at pc_if.
- cmp_equal  in  1  ID comparator: forwarded rs == rt.
- cmp_bgez  in  1  ID comparator: signed forwarded rs >= 0.
- rs_data  in  32  forwarded rs value (jr/jalr target).
- pc_if  out  32  current fetch address.
- id_instr  out  32  IF/ID instruction.
- id_pc4  out  32  IF/ID PC+4.
- id_valid  out  1  IF/ID holds a real instruction.
- redirect  out  1  control transfer taken this cycle.
- taken_count  out  32  saturating count of taken transfers.

Behaviour:
- Reset (sync, reset_n=0 at clk edge; has priority over stall):
  - pc_if=RESET_PC, id_instr=0, id_pc4=0, id_valid=0, taken_count=0.
- Decode of id_instr (combinational), with op=[31:26], rt=[20:16], funct=[5:0]:
  - beq op=000100.
  - bne op=000101.
  - bgez op=000001, rt=00001.
  - bltz op=000001, rt=00000.
  - j op=000010.
  - jal op=000011.
  - jr op=0, funct=001000.
  - jalr op=0, funct=001001.
- Take condition:
  - beq: cmp_equal.
  - bne: !cmp_equal.
  - bgez: cmp_bgez.
  - bltz: !cmp_bgez.
  - j/jal/jr/jalr: always.
  - All other opcodes: never.
- redirect = id_valid & !stall & take.
- Targets (all arithmetic is 32-bit modulo; wrap at 2^32 is silent):
  - Branch: id_pc4 + (sign-extended imm16 << 2).
  - j/jal: {id_pc4[31:28], instr[25:0], 2'b00}.
  - jr/jalr: rs_data, no alignment check.
- npc = redirect ? target : pc_if+4.
- Per cycle, when !stall:
  - pc_if <= npc.
  - If DELAY_SLOT=0 and redirect: IF/ID <= {0, 0}, id_valid <= 0.
  - Otherwise: IF/ID <= {instr_if, pc_if+4}, id_valid <= 1.
- stall=1:
  - pc_if, IF/ID and id_valid hold.
  - redirect forced 0; the branch re-evaluates when stall drops, since operands are not yet final.
- taken_count:
  - Increments on every cycle with redirect=1.
  - Saturates at 32'hFFFF_FFFF; no wrap.
- id_valid=0: no redirect even if id_instr decodes as a branch.
- Latency:
  - Instruction visible in ID one cycle after its fetch.
  - Redirect affects pc_if on the next edge.
  - Exactly one delay-slot instruction follows when DELAY_SLOT=1.
- Reset asserted mid-stall or mid-redirect: the reset state wins at that edge; no pending redirect survives.

Decomposition:
- Shared package (mips_defs):
  - Opcode/funct/rt constants: OP_BEQ, OP_BNE, OP_REGIMM, OP_J, OP_JAL, FN_JR, FN_JALR, RT_BGEZ, RT_BLTZ.
  - RESET_PC default.
  - NOP encoding 32'h0.
- Sub-module npc_calc:
  - Combinational decode, take and target logic.
  - Inputs: id_instr, id_pc4, pc_if, cmp flags, rs_data.
  - Outputs: take, npc.
- Top module keeps the registers, the stall handling and the counter.

Test Plan:
- Reset then 3 free-running cycles, no stall -> pc_if 0x3000, 0x3004, 0x3008, 0x300C; id_pc4 lags one cycle (0x3004 in cycle 1); id_valid rises after the first edge.
- beq at 0x3000 with imm=0x0003 and cmp_equal=1 -> redirect=1 in ID; delay slot 0x3004 enters ID; pc_if=0x3010; taken_count=1. Same with cmp_equal=0 -> pc_if continues sequentially (0x3008).
- bgez with imm=0xFFFF (backward) at id_pc4=0x3008 -> target 0x3004 when cmp_bgez=1. bltz with cmp_bgez=1 -> no redirect.
- jal instr_index=0x0000C10 at id_pc4=0x3004 -> pc_if=0x0000_3040. jr with rs_data=0x0000_3100 -> pc_if=0x3100.
- stall=1 for 2 cycles while beq sits in ID with cmp_equal=1 -> pc_if and IF/ID frozen, redirect=0; stall drops -> redirect=1 on that cycle.
- DELAY_SLOT=0 with j taken -> next id_instr=0, id_valid=0. Separately: force taken_count=0xFFFF_FFFF via a long run and check it saturates. Separately: reset_n=0 during stall -> pc_if=0x3000 on the next edge.
